iob_sram_1rw1r_ctrl: RTL and testbench

- Initiator-side controller for the 1rw1r OpenRAM SRAM macro (32x512, byte write mask).
- Bus side: two IOb native channels. Channel A is read/write and maps to macro port 0. Channel B is read-only and maps to macro port 1.
- Generates all macro control pins as registered outputs, captures read data at fixed latency, and resolves same-address write/read collisions between the two macro ports.
- Sits between the system interconnect and the SRAM macro in the ASIC memory subsystem.

---
 rtl/iob_sram_1rw1r_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_iob_sram_1rw1r_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_sram_1rw1r_ctrl.sv
// Initiator-side controller for a 1rw1r SRAM macro: channel A (rw) on port 0, channel B (ro) on port 1.
// Optional power-up zero sweep of port 0 enabled by defining IOB_SRAM_CTRL_CLEAR_EN.
module iob_sram_1rw1r_ctrl #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 32,
  localparam int unsigned NUM_WMASKS = DATA_W / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_valid,
  input  logic [ADDR_W-1:0]     a_addr,
  input  logic [DATA_W-1:0]     a_wdata,
  input  logic [NUM_WMASKS-1:0] a_wstrb,
  output logic [DATA_W-1:0]     a_rdata,
  output logic                  a_ready,
  input  logic                  b_valid,
  input  logic [ADDR_W-1:0]     b_addr,
  output logic [DATA_W-1:0]     b_rdata,
  output logic                  b_ready,
  output logic                  busy,
  output logic                  sram_clk0,
  output logic                  sram_clk1,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_W-1:0]     sram_addr0,
  output logic [DATA_W-1:0]     sram_din0,
  input  logic [DATA_W-1:0]     sram_dout0,
  output logic                  sram_csb1,
  output logic [ADDR_W-1:0]     sram_addr1,
  input  logic [DATA_W-1:0]     sram_dout1
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e                a_state_q, a_state_d, b_state_q, b_state_d;
  logic                  csb0_q, csb0_d, web0_q, web0_d, csb1_q, csb1_d;
  logic [NUM_WMASKS-1:0] wmask0_q, wmask0_d;
  logic [ADDR_W-1:0]     addr0_q, addr0_d, addr1_q, addr1_d;
  logic [DATA_W-1:0]     din0_q, din0_d, a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic                  a_ready_q, a_ready_d, b_ready_q, b_ready_d;
  logic                  b_block;

`ifdef IOB_SRAM_CTRL_CLEAR_EN
  logic busy_q, busy_d, clr_done_q, clr_done_d;
  assign busy = busy_q;
`else
  assign busy = 1'b0;
`endif

  // A write to the address B wants to read goes first so B observes the new data.
  assign b_block = (a_state_q == StIdle) && a_valid && (|a_wstrb) && (a_addr == b_addr);

  always_comb begin
    a_state_d = a_state_q;
    b_state_d = b_state_q;
    csb0_d    = csb0_q;
    web0_d    = web0_q;
    wmask0_d  = wmask0_q;
    addr0_d   = addr0_q;
    din0_d    = din0_q;
    csb1_d    = csb1_q;
    addr1_d   = addr1_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    a_ready_d = 1'b0;
    b_ready_d = 1'b0;

    unique case (a_state_q)
      StIdle: begin
        if (a_valid) begin
          csb0_d    = 1'b0;
          web0_d    = ~|a_wstrb;
          wmask0_d  = a_wstrb;
          addr0_d   = a_addr;
          din0_d    = a_wdata;
          a_state_d = StIssue;
        end
      end
      StIssue: begin
        csb0_d    = 1'b1;
        web0_d    = 1'b1;
        a_state_d = StWait;
      end
      StWait: begin
        // wmask0 still holds the strobes, so all-zero identifies a read.
        if (~|wmask0_q) a_rdata_d = sram_dout0;
        a_ready_d = 1'b1;
        a_state_d = StResp;
      end
      default: a_state_d = StIdle;
    endcase

    unique case (b_state_q)
      StIdle: begin
        if (b_valid && !b_block) begin
          csb1_d    = 1'b0;
          addr1_d   = b_addr;
          b_state_d = StIssue;
        end
      end
      StIssue: begin
        csb1_d    = 1'b1;
        b_state_d = StWait;
      end
      StWait: begin
        b_rdata_d = sram_dout1;
        b_ready_d = 1'b1;
        b_state_d = StResp;
      end
      default: b_state_d = StIdle;
    endcase

`ifdef IOB_SRAM_CTRL_CLEAR_EN
    busy_d     = busy_q;
    clr_done_d = clr_done_q;
    if (!clr_done_q) begin
      a_state_d = StIdle;
      b_state_d = StIdle;
      csb1_d    = csb1_q;
      addr1_d   = addr1_q;
      a_rdata_d = a_rdata_q;
      b_rdata_d = b_rdata_q;
      a_ready_d = 1'b0;
      b_ready_d = 1'b0;
      busy_d    = 1'b1;
      csb0_d    = 1'b0;
      web0_d    = 1'b0;
      wmask0_d  = '1;
      din0_d    = '0;
      if (!busy_q) begin
        addr0_d = '0;
      end else if (addr0_q == '1) begin
        busy_d     = 1'b0;
        clr_done_d = 1'b1;
        csb0_d     = 1'b1;
        web0_d     = 1'b1;
      end else begin
        addr0_d = addr0_q + ADDR_W'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_state_q  <= StIdle;
      b_state_q  <= StIdle;
      csb0_q     <= 1'b1;
      web0_q     <= 1'b1;
      wmask0_q   <= '0;
      addr0_q    <= '0;
      din0_q     <= '0;
      csb1_q     <= 1'b1;
      addr1_q    <= '0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
      a_ready_q  <= 1'b0;
      b_ready_q  <= 1'b0;
`ifdef IOB_SRAM_CTRL_CLEAR_EN
      busy_q     <= 1'b0;
      clr_done_q <= 1'b0;
`endif
    end else begin
      a_state_q  <= a_state_d;
      b_state_q  <= b_state_d;
      csb0_q     <= csb0_d;
      web0_q     <= web0_d;
      wmask0_q   <= wmask0_d;
      addr0_q    <= addr0_d;
      din0_q     <= din0_d;
      csb1_q     <= csb1_d;
      addr1_q    <= addr1_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
      a_ready_q  <= a_ready_d;
      b_ready_q  <= b_ready_d;
`ifdef IOB_SRAM_CTRL_CLEAR_EN
      busy_q     <= busy_d;
      clr_done_q <= clr_done_d;
`endif
    end
  end

  assign sram_clk0   = clk;
  assign sram_clk1   = clk;
  assign sram_csb0   = csb0_q;
  assign sram_web0   = web0_q;
  assign sram_wmask0 = wmask0_q;
  assign sram_addr0  = addr0_q;
  assign sram_din0   = din0_q;
  assign sram_csb1   = csb1_q;
  assign sram_addr1  = addr1_q;
  assign a_rdata     = a_rdata_q;
  assign a_ready     = a_ready_q;
  assign b_rdata     = b_rdata_q;
  assign b_ready     = b_ready_q;

endmodule

// File: tb/tb_iob_sram_1rw1r_ctrl.sv
// Scoreboard bench for iob_sram_1rw1r_ctrl with a behavioural SRAM macro and a word-level memory model.
// Also covers the IOB_SRAM_CTRL_CLEAR_EN build.
module tb_iob_sram_1rw1r_ctrl;
  localparam int AW = 9;
  localparam int DW = 32;
  localparam int NM = DW / 8;
  localparam int DEPTH = 1 << AW;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_valid, b_valid, a_ready, b_ready, busy;
  logic [AW-1:0] a_addr, b_addr, sram_addr0, sram_addr1;
  logic [DW-1:0] a_wdata, a_rdata, b_rdata, sram_din0, sram_dout0, sram_dout1;
  logic [NM-1:0] a_wstrb, sram_wmask0;
  logic          sram_clk0, sram_clk1, sram_csb0, sram_web0, sram_csb1;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] a_last;
  exp_t          exp_a_q[$], exp_b_q[$];
  int            cyc = 0;
  int            nchk = 0;
  int            nerr = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  iob_sram_1rw1r_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_addr(a_addr), .a_wdata(a_wdata), .a_wstrb(a_wstrb),
    .a_rdata(a_rdata), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_rdata(b_rdata), .b_ready(b_ready),
    .busy(busy), .sram_clk0(sram_clk0), .sram_clk1(sram_clk1),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
    .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0),
    .sram_csb1(sram_csb1), .sram_addr1(sram_addr1), .sram_dout1(sram_dout1)
  );

  // Behavioural 1rw1r macro: pins sampled on the rising edge, data out one edge later.
  always @(posedge sram_clk0) begin
    if (!sram_csb0) begin
      if (!sram_web0) begin
        for (int i = 0; i < NM; i++)
          if (sram_wmask0[i]) mem[sram_addr0][i*8 +: 8] <= sram_din0[i*8 +: 8];
      end else begin
        sram_dout0 <= mem[sram_addr0];
      end
    end
  end

  always @(posedge sram_clk1) begin
    if (!sram_csb1) sram_dout1 <= mem[sram_addr1];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every ready pulse pops one expectation (data and completion cycle).
  always @(negedge clk) begin
    exp_t e;
    if (a_ready) begin
      if (exp_a_q.size() == 0) begin
        check("a_unexpected_ready", 64'(a_ready), 64'(0));
      end else begin
        e = exp_a_q.pop_front();
        check("a_rdata", 64'(a_rdata), 64'(e.data));
        if (e.cyc >= 0) check("a_ready_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    if (b_ready) begin
      if (exp_b_q.size() == 0) begin
        check("b_unexpected_ready", 64'(b_ready), 64'(0));
      end else begin
        e = exp_b_q.pop_front();
        check("b_rdata", 64'(b_rdata), 64'(e.data));
        if (e.cyc >= 0) check("b_ready_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_csb0"}, 64'(sram_csb0), 64'(1));
    check({tag, "_web0"}, 64'(sram_web0), 64'(1));
    check({tag, "_wmask0"}, 64'(sram_wmask0), 64'(0));
    check({tag, "_addr0_din0"}, {23'd0, sram_addr0, sram_din0}, 64'(0));
    check({tag, "_csb1"}, 64'(sram_csb1), 64'(1));
    check({tag, "_addr1"}, 64'(sram_addr1), 64'(0));
    check({tag, "_rdata"}, {a_rdata, b_rdata}, 64'(0));
    check({tag, "_ready_busy"}, {61'd0, a_ready, b_ready, busy}, 64'(0));
  endtask

  // Holds requests until their ready is seen, bounded by limit cycles.
  task automatic run_wait(input bit wa, input bit wb, input int limit);
    bit da, db;
    int n;
    da = !wa;
    db = !wb;
    n  = 0;
    while (!(da && db) && n < limit) begin
      @(negedge clk);
      n++;
      if (a_ready) begin da = 1'b1; a_valid = 1'b0; end
      if (b_ready) begin db = 1'b1; b_valid = 1'b0; end
    end
    if (!(da && db)) begin
      check("ready_timeout", {62'd0, da, db}, {62'd0, 1'b1, 1'b1});
      a_valid = 1'b0;
      b_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic do_round(input bit ae, input bit awe, input logic [AW-1:0] aa,
                          input logic [DW-1:0] awd, input logic [NM-1:0] ast,
                          input bit be, input logic [AW-1:0] ba);
    exp_t e;
    int   stall;
    stall = (ae && awe && be && aa == ba) ? 1 : 0;
    if (ae) begin
      if (awe) begin
        for (int i = 0; i < NM; i++) if (ast[i]) ref_mem[aa][i*8 +: 8] = awd[i*8 +: 8];
        e.data = a_last;
      end else begin
        e.data = ref_mem[aa];
        a_last = e.data;
      end
      e.cyc = cyc + 3;
      exp_a_q.push_back(e);
      a_valid = 1'b1;
      a_addr  = aa;
      a_wdata = awd;
      a_wstrb = awe ? ast : '0;
    end
    if (be) begin
      e.data = ref_mem[ba];
      e.cyc  = cyc + 3 + stall;
      exp_b_q.push_back(e);
      b_valid = 1'b1;
      b_addr  = ba;
    end
    run_wait(ae, be, 20);
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

`ifdef IOB_SRAM_CTRL_CLEAR_EN
  // Called at the negedge where rst was just released; a held read of the top word
  // must wait for the sweep and then return zero.
  task automatic sweep();
    exp_t e;
    int   n, busy_cyc;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    a_valid = 1'b1;
    a_addr  = AW'(DEPTH - 1);
    a_wstrb = '0;
    a_wdata = $urandom;
    e.data  = '0;
    e.cyc   = -1;
    exp_a_q.push_back(e);
    a_last   = '0;
    n        = 0;
    busy_cyc = 0;
    while (!busy && n < 4) begin @(negedge clk); n++; end
    while (busy && n < 2000) begin busy_cyc++; @(negedge clk); n++; end
    check("busy_cycles", 64'(busy_cyc), 64'(DEPTH));
    run_wait(1'b1, 1'b0, 50);
  endtask
`endif

  initial begin
    logic [AW-1:0] ra, rb;
    bit            ae, awe, be;
    rst = 1'b1;
    a_valid = 1'b0; b_valid = 1'b0;
    a_addr = '0; b_addr = '0; a_wdata = '0; a_wstrb = '0;
    a_last = '0;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = DW'(i);
      ref_mem[i] = DW'(i);
    end
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
`ifdef IOB_SRAM_CTRL_CLEAR_EN
    sweep();
`endif

    // Directed cases
    do_round(1, 1, 9'd5, 32'hDEADBEEF, 4'hF, 0, 9'd0);
    do_round(1, 0, 9'd5, 32'h0, 4'h0, 0, 9'd0);
    do_round(1, 1, 9'd7, 32'h11223344, 4'hF, 0, 9'd0);
    do_round(1, 1, 9'd7, 32'hAABBCCDD, 4'h5, 0, 9'd0);
    do_round(1, 0, 9'd7, 32'h0, 4'h0, 0, 9'd0);
    do_round(1, 1, 9'd3, 32'h12345678, 4'hF, 1, 9'd3);
    do_round(1, 0, 9'd10, 32'h0, 4'h0, 1, 9'd20);
    do_round(1, 0, 9'd7, 32'h0, 4'h0, 1, 9'd7);
    do_round(1, 1, 9'd12, 32'hCAFEF00D, 4'h6, 1, 9'd12);

    // Randomized traffic on a small address window to provoke collisions
    for (int r = 0; r < 150; r++) begin
      ae  = ($urandom_range(0, 3) != 0);
      awe = $urandom_range(0, 1) == 1;
      be  = $urandom_range(0, 1) == 1;
      ra  = AW'($urandom_range(0, 15));
      rb  = ($urandom_range(0, 1) == 1) ? ra : AW'($urandom_range(0, 15));
      if (ae || be)
        do_round(ae, awe, ra, $urandom, NM'($urandom_range(1, 15)), be, rb);
    end

    // Reset while a read sits in WAIT: the transaction is dropped silently
    a_valid = 1'b1; a_addr = 9'd5; a_wstrb = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    a_valid = 1'b0;
    @(negedge clk);
    check_reset_vals("midop");
    @(negedge clk);
    check("midop_no_ready", 64'(a_ready), 64'(0));
    rst = 1'b0;
    a_last = '0;
`ifdef IOB_SRAM_CTRL_CLEAR_EN
    sweep();
`endif
    do_round(1, 0, 9'd5, 32'h0, 4'h0, 1, 9'd7);
    do_round(1, 1, 9'd9, 32'h0BADF00D, 4'h9, 1, 9'd9);
    do_round(1, 0, 9'd9, 32'h0, 4'h0, 0, 9'd0);

    repeat (5) @(negedge clk);
    check("a_queue_drained", 64'(exp_a_q.size()), 64'(0));
    check("b_queue_drained", 64'(exp_b_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end

endmodule
